// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiply-accumulate: result = (a*b mod f) ^ acc.
// Consumes D bits of a per cycle, MSB first; f(x) = x^M + POLY.
module gf2m_digit_mult #(
    parameter int unsigned  M    = 233,
    parameter int unsigned  D    = 32,
    parameter logic [M-1:0] POLY = ({{(M-1){1'b0}}, 1'b1} << 74) | {{(M-1){1'b0}}, 1'b1}
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    input  logic [M-1:0] acc_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [M-1:0] result_o
);

    localparam int unsigned N  = (M + D - 1) / D;
    localparam int unsigned W  = N * D;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q;
    logic [W-1:0]    a_sh_q;
    logic [M-1:0]    b_q;
    logic [M-1:0]    acc_q;
    logic [M-1:0]    c_q;
    logic [M-1:0]    c_d;
    logic [CW-1:0]   ctr_q;
    logic            busy_q;
    logic            done_q;
    logic [M-1:0]    result_q;
    logic [D-1:0]    digit;

    assign digit = a_sh_q[W-1 -: D];

    // One shift-reduce-add step per digit bit keeps c below degree M throughout.
    always_comb begin
        c_d = c_q;
        for (int j = int'(D) - 1; j >= 0; j--) begin
            c_d = {c_d[M-2:0], 1'b0} ^ (c_d[M-1] ? POLY : '0);
            if (digit[j]) begin
                c_d = c_d ^ b_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            c_q      <= '0;
            ctr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sh_q  <= W'(a_i);
                        b_q     <= b_i;
                        acc_q   <= acc_i;
                        c_q     <= '0;
                        ctr_q   <= CW'(N - 1);
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    c_q    <= c_d;
                    a_sh_q <= a_sh_q << D;
                    ctr_q  <= ctr_q - CW'(1);
                    if (ctr_q == '0) begin
                        result_q <= c_d ^ acc_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
